// File: rtl/core_pkg.sv
// Shared decode definitions for the operand/bypass stage: opcodes, operand
// select encodings, per-lane decode record and the split FSM states.
package core_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  typedef enum logic [2:0] {SEL_RS, SEL_IMM, SEL_PC, SEL_ZERO, SEL_FOUR} op_sel_e;

  typedef enum logic {ST_NORMAL, ST_SPLIT} state_e;

  typedef struct packed {
    op_sel_e    op1_sel;
    op_sel_e    op2_sel;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } lane_dec_t;

  // Opcode -> operand sources and register usage.
  function automatic lane_dec_t decode(input logic [31:0] instr);
    lane_dec_t d;
    d.rd        = instr[11:7];
    d.rs1       = instr[19:15];
    d.rs2       = instr[24:20];
    d.op1_sel   = SEL_RS;
    d.op2_sel   = SEL_RS;
    d.uses_rs1  = 1'b1;
    d.uses_rs2  = 1'b0;
    d.writes_rd = 1'b1;
    case (instr[6:0])
      OPC_R: d.uses_rs2 = 1'b1;
      OPC_B: begin
        d.uses_rs2  = 1'b1;
        d.writes_rd = 1'b0;
      end
      OPC_STORE: begin
        d.op2_sel   = SEL_IMM;
        d.uses_rs2  = 1'b1;
        d.writes_rd = 1'b0;
      end
      OPC_LOAD, OPC_OPIMM, OPC_JALR: d.op2_sel = SEL_IMM;
      OPC_LUI: begin
        d.op1_sel  = SEL_IMM;
        d.op2_sel  = SEL_ZERO;
        d.uses_rs1 = 1'b0;
      end
      OPC_AUIPC: begin
        d.op1_sel  = SEL_PC;
        d.op2_sel  = SEL_IMM;
        d.uses_rs1 = 1'b0;
      end
      OPC_JAL: begin
        d.op1_sel  = SEL_PC;
        d.op2_sel  = SEL_FOUR;
        d.uses_rs1 = 1'b0;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/operand_sel_lane.sv
// One issue lane: decode, bypass mux for rs1/rs2 and operand selection.
// Purely combinational; also reports register usage for hazard checks.
module operand_sel_lane
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FWD_SRCS = 2
) (
  input  logic [31:0]            instr_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        imm_i,
  input  logic [XLEN-1:0]        rs1_data_i,
  input  logic [XLEN-1:0]        rs2_data_i,
  input  logic [FWD_SRCS-1:0]    fwd_valid_i,
  input  logic [FWD_SRCS*5-1:0]  fwd_rd_i,
  input  logic [FWD_SRCS*XLEN-1:0] fwd_data_i,
  input  logic [FWD_SRCS-1:0]    fwd_pending_i,
  output logic [XLEN-1:0]        op1_o,
  output logic [XLEN-1:0]        op2_o,
  output logic [XLEN-1:0]        rs2_val_o,
  output logic                   pending_o,
  output logic [4:0]             rd_o,
  output logic [4:0]             rs1_o,
  output logic [4:0]             rs2_o,
  output logic                   uses_rs1_o,
  output logic                   uses_rs2_o,
  output logic                   writes_rd_o
);

  lane_dec_t       dec;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_pend;
  logic            rs2_pend;

  assign dec         = decode(instr_i);
  assign rd_o        = dec.rd;
  assign rs1_o       = dec.rs1;
  assign rs2_o       = dec.rs2;
  assign uses_rs1_o  = dec.uses_rs1;
  assign uses_rs2_o  = dec.uses_rs2;
  assign writes_rd_o = dec.writes_rd;
  assign rs2_val_o   = rs2_val;

  // Bypass mux: scan from oldest source down so the lowest index wins; x0 never matches.
  always_comb begin
    rs1_val  = rs1_data_i;
    rs2_val  = rs2_data_i;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = FWD_SRCS - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && dec.rs1 != 5'd0 && fwd_rd_i[i*5 +: 5] == dec.rs1) begin
        rs1_val  = fwd_data_i[i*XLEN +: XLEN];
        rs1_pend = fwd_pending_i[i];
      end
      if (fwd_valid_i[i] && dec.rs2 != 5'd0 && fwd_rd_i[i*5 +: 5] == dec.rs2) begin
        rs2_val  = fwd_data_i[i*XLEN +: XLEN];
        rs2_pend = fwd_pending_i[i];
      end
    end
    pending_o = (dec.uses_rs1 && rs1_pend) || (dec.uses_rs2 && rs2_pend);
  end

  // Operand selection from the decoded sources.
  always_comb begin
    case (dec.op1_sel)
      SEL_RS:   op1_o = rs1_val;
      SEL_IMM:  op1_o = imm_i;
      SEL_PC:   op1_o = pc_i;
      SEL_FOUR: op1_o = XLEN'(4);
      default:  op1_o = '0;
    endcase
    case (dec.op2_sel)
      SEL_RS:   op2_o = rs2_val;
      SEL_IMM:  op2_o = imm_i;
      SEL_PC:   op2_o = pc_i;
      SEL_FOUR: op2_o = XLEN'(4);
      default:  op2_o = '0;
    endcase
  end

endmodule

// File: rtl/operand_bypass_stage.sv
// Multi-lane operand generation with bypass and the ID/EX register.
// Intra-bundle RAW dependencies split the bundle over several beats; a
// pending (load) bypass source stalls the whole capture.
module operand_bypass_stage
  import core_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LANES    = 2,
  parameter int FWD_SRCS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_en,
  input  logic [LANES*32-1:0]      in_instr,
  input  logic [LANES*XLEN-1:0]    in_pc,
  input  logic [LANES*XLEN-1:0]    in_imm,
  input  logic [LANES*XLEN-1:0]    in_rs1_data,
  input  logic [LANES*XLEN-1:0]    in_rs2_data,
  input  logic [FWD_SRCS-1:0]      fwd_valid,
  input  logic [FWD_SRCS*5-1:0]    fwd_rd,
  input  logic [FWD_SRCS*XLEN-1:0] fwd_data,
  input  logic [FWD_SRCS-1:0]      fwd_pending,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_lane_en,
  output logic [LANES*32-1:0]      out_instr,
  output logic [LANES*XLEN-1:0]    out_op1,
  output logic [LANES*XLEN-1:0]    out_op2,
  output logic [LANES*XLEN-1:0]    out_rs2_val
);

  logic [LANES*XLEN-1:0] lane_op1, lane_op2, lane_rs2v;
  logic [LANES-1:0]      lane_pend, lane_u1, lane_u2, lane_wr;
  logic [4:0]            lane_rd  [LANES];
  logic [4:0]            lane_rs1 [LANES];
  logic [4:0]            lane_rs2 [LANES];

  state_e           state_q, state_d;
  logic [LANES-1:0] issued_q, issued_d;
  logic [LANES-1:0] eval_mask, cap_mask;
  logic             split_found, raw, stall, advance, capture;

  logic                  out_valid_q;
  logic [LANES-1:0]      out_lane_en_q;
  logic [LANES*32-1:0]   out_instr_q;
  logic [LANES*XLEN-1:0] out_op1_q, out_op2_q, out_rs2_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    operand_sel_lane #(.XLEN(XLEN), .FWD_SRCS(FWD_SRCS)) u_lane (
      .instr_i       (in_instr[gi*32 +: 32]),
      .pc_i          (in_pc[gi*XLEN +: XLEN]),
      .imm_i         (in_imm[gi*XLEN +: XLEN]),
      .rs1_data_i    (in_rs1_data[gi*XLEN +: XLEN]),
      .rs2_data_i    (in_rs2_data[gi*XLEN +: XLEN]),
      .fwd_valid_i   (fwd_valid),
      .fwd_rd_i      (fwd_rd),
      .fwd_data_i    (fwd_data),
      .fwd_pending_i (fwd_pending),
      .op1_o         (lane_op1[gi*XLEN +: XLEN]),
      .op2_o         (lane_op2[gi*XLEN +: XLEN]),
      .rs2_val_o     (lane_rs2v[gi*XLEN +: XLEN]),
      .pending_o     (lane_pend[gi]),
      .rd_o          (lane_rd[gi]),
      .rs1_o         (lane_rs1[gi]),
      .rs2_o         (lane_rs2[gi]),
      .uses_rs1_o    (lane_u1[gi]),
      .uses_rs2_o    (lane_u2[gi]),
      .writes_rd_o   (lane_wr[gi])
    );
  end

  // Pick the lanes issued this beat: un-issued enabled lanes up to the first RAW consumer.
  always_comb begin
    eval_mask   = in_lane_en & ~issued_q;
    cap_mask    = '0;
    split_found = 1'b0;
    raw         = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      raw = 1'b0;
      for (int j = 0; j < LANES; j++) begin
        if (j < k && eval_mask[j] && lane_wr[j] && lane_rd[j] != 5'd0 &&
            ((lane_u1[k] && lane_rs1[k] == lane_rd[j]) ||
             (lane_u2[k] && lane_rs2[k] == lane_rd[j])))
          raw = 1'b1;
      end
      if (eval_mask[k] && !split_found) begin
        if (raw) split_found = 1'b1;
        else     cap_mask[k] = 1'b1;
      end
    end
    stall = |(cap_mask & lane_pend);
  end

  assign advance = !out_valid_q || out_ready;
  assign capture = !flush && advance && in_valid && !stall;

  // Split FSM next state, issued mask and upstream handshake.
  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    in_ready = rst_n && !flush && advance && !stall && !split_found;
    if (flush) begin
      state_d  = ST_NORMAL;
      issued_d = '0;
    end else if (capture) begin
      if (split_found) begin
        state_d  = ST_SPLIT;
        issued_d = issued_q | cap_mask;
      end else begin
        state_d  = ST_NORMAL;
        issued_d = '0;
      end
    end
  end

  // FSM state and issued-lane mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
    end
  end

  // ID/EX register: load on capture, drop valid on flush or when EX drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_lane_en_q <= '0;
      out_instr_q   <= '0;
      out_op1_q     <= '0;
      out_op2_q     <= '0;
      out_rs2_q     <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (capture) begin
      out_valid_q   <= 1'b1;
      out_lane_en_q <= cap_mask;
      out_instr_q   <= in_instr;
      out_op1_q     <= lane_op1;
      out_op2_q     <= lane_op2;
      out_rs2_q     <= lane_rs2v;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_lane_en = out_lane_en_q;
  assign out_instr   = out_instr_q;
  assign out_op1     = out_op1_q;
  assign out_op2     = out_op2_q;
  assign out_rs2_val = out_rs2_q;

endmodule
